sys_redirect: RTL and testbench

Control-flow redirect stage directly downstream of the CSR/system unit. It captures jump requests from the system unit (mret/sret/uret, ecall, fence.i) and from the branch unit, picks the older one, and flushes the pipeline. It then presents one registered redirect PC to fetch under a valid/ready handshake and holds issue through a fixed drain window. Younger requests that arrive while a redirect is in flight are wrong-path and are discarded.

---
 rtl/sys_redirect_pkg.sv | 23 ++
 rtl/sys_redirect.sv | 121 ++++++++++++
 tb/tb_sys_redirect.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/sys_redirect_pkg.sv
// Shared definitions for the redirect stage: FSM state encoding, drain
// counter width and the PC alignment helper.
// Optional feature macro: SYS_REDIRECT_PERF_EN (see sys_redirect.sv).
`ifndef XLEN
`define XLEN 32
`endif

package sys_redirect_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int CNT_W = 4;

  // Redirect targets are halfword aligned; bit 0 is never sent to fetch.
  function automatic logic [`XLEN-1:0] align_pc(input logic [`XLEN-1:0] pc);
    return {pc[`XLEN-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/sys_redirect.sv
// Control-flow redirect stage. Captures the older of the branch/system
// jump requests, flushes the pipeline, hands one registered PC to fetch
// and holds issue through a fixed drain window after fetch accepts.
// Define SYS_REDIRECT_PERF_EN to build the redirect/drop perf counters;
// without it both counter ports read 0 and no counter flops exist.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no redirect in flight; any valid request is captured
// REQ   | redirect offered to fetch, waiting for fetch_rdy
// DRAIN | fetch accepted; issue held while cnt counts down to 0
module sys_redirect
  import sys_redirect_pkg::*;
#(
  parameter int DRAIN_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br_jump_vld,
  input  logic [`XLEN-1:0]  br_jump_pc,
  input  logic              sys_jump_vld,
  input  logic [`XLEN-1:0]  sys_jump_pc,
  input  logic              fetch_rdy,
  output logic              fetch_redir_vld,
  output logic [`XLEN-1:0]  fetch_redir_pc,
  output logic              flush,
  output logic              hold,
  output logic [31:0]       redir_count,
  output logic [31:0]       drop_count
);

  localparam logic [CNT_W-1:0] DRAIN_LOAD =
    (DRAIN_CYC == 0) ? '0 : CNT_W'(DRAIN_CYC - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [`XLEN-1:0]   pc_q;
  logic               flush_q;
  logic               vld_q;

  // Redirect FSM; branch requests are always older, so they win a tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pc_q    <= '0;
      flush_q <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (br_jump_vld || sys_jump_vld) begin
            pc_q    <= align_pc(br_jump_vld ? br_jump_pc : sys_jump_pc);
            flush_q <= 1'b1;
            vld_q   <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          flush_q <= 1'b0;
          if (fetch_rdy) begin
            vld_q <= 1'b0;
            if (DRAIN_CYC == 0) begin
              state <= IDLE;
            end else begin
              cnt   <= DRAIN_LOAD;
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: begin
          state   <= IDLE;
          flush_q <= 1'b0;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_redir_vld = vld_q;
  assign fetch_redir_pc  = pc_q;
  assign flush           = flush_q;

  // The capture cycle is held too, so issue never sees the wrong path.
  assign hold = (state != IDLE) | br_jump_vld | sys_jump_vld;

`ifdef SYS_REDIRECT_PERF_EN
  logic [1:0]  drop_inc;
  logic [31:0] redir_cnt_q;
  logic [31:0] drop_cnt_q;

  // In IDLE only the losing sys request of a tie is dropped; otherwise all are.
  always_comb begin
    drop_inc = 2'd0;
    if (state == IDLE) drop_inc = {1'b0, br_jump_vld & sys_jump_vld};
    else               drop_inc = {1'b0, br_jump_vld} + {1'b0, sys_jump_vld};
  end

  // Free-running wrap-around perf counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redir_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (vld_q && fetch_rdy) redir_cnt_q <= redir_cnt_q + 32'd1;
      drop_cnt_q <= drop_cnt_q + {30'd0, drop_inc};
    end
  end

  assign redir_count = redir_cnt_q;
  assign drop_count  = drop_cnt_q;
`else
  assign redir_count = 32'd0;
  assign drop_count  = 32'd0;
`endif

endmodule

// File: tb/tb_sys_redirect.sv
// Bench for sys_redirect: two instances (drain 2 and drain 0) share one
// stimulus stream and are compared every cycle against a transaction-level
// model of the redirect protocol.
`ifndef XLEN
`define XLEN 32
`endif

module tb_sys_redirect;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              br_jump_vld = 1'b0;
  logic [`XLEN-1:0]  br_jump_pc = '0;
  logic              sys_jump_vld = 1'b0;
  logic [`XLEN-1:0]  sys_jump_pc = '0;
  logic              fetch_rdy = 1'b0;

  logic              vld [2];
  logic [`XLEN-1:0]  rpc [2];
  logic              fl [2];
  logic              hd [2];
  logic [31:0]       rc [2];
  logic [31:0]       dc [2];

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sys_redirect #(.DRAIN_CYC(2)) dut2 (
    .clk(clk), .rst(rst),
    .br_jump_vld(br_jump_vld), .br_jump_pc(br_jump_pc),
    .sys_jump_vld(sys_jump_vld), .sys_jump_pc(sys_jump_pc),
    .fetch_rdy(fetch_rdy),
    .fetch_redir_vld(vld[0]), .fetch_redir_pc(rpc[0]),
    .flush(fl[0]), .hold(hd[0]),
    .redir_count(rc[0]), .drop_count(dc[0])
  );

  sys_redirect #(.DRAIN_CYC(0)) dut0 (
    .clk(clk), .rst(rst),
    .br_jump_vld(br_jump_vld), .br_jump_pc(br_jump_pc),
    .sys_jump_vld(sys_jump_vld), .sys_jump_pc(sys_jump_pc),
    .fetch_rdy(fetch_rdy),
    .fetch_redir_vld(vld[1]), .fetch_redir_pc(rpc[1]),
    .flush(fl[1]), .hold(hd[1]),
    .redir_count(rc[1]), .drop_count(dc[1])
  );

  // Reference model: a redirect is either offered (m_req), in its drain
  // window (m_busy cycles left), or absent.
  int              m_drain [2] = '{2, 0};
  bit              m_req   [2];
  bit              m_first [2];
  int              m_busy  [2];
  logic [`XLEN-1:0] m_pc   [2];
  int unsigned     m_redir [2];
  int unsigned     m_drop  [2];

  logic [`XLEN-1:0] last_pc0;
  logic             last_fl0;
  logic             last_vld0;
  logic             last_hd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_req[i] = 0; m_first[i] = 0; m_busy[i] = 0; m_pc[i] = '0;
      m_redir[i] = 0; m_drop[i] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 2; i++) begin
      logic [31:0] erc, edc;
`ifdef SYS_REDIRECT_PERF_EN
      erc = m_redir[i]; edc = m_drop[i];
`else
      erc = 32'd0; edc = 32'd0;
`endif
      chk($sformatf("%s.d%0d.vld", tag, m_drain[i]), {31'd0, vld[i]}, {31'd0, m_req[i]});
      chk($sformatf("%s.d%0d.pc", tag, m_drain[i]), rpc[i], m_pc[i]);
      chk($sformatf("%s.d%0d.flush", tag, m_drain[i]), {31'd0, fl[i]}, {31'd0, m_first[i]});
      chk($sformatf("%s.d%0d.hold", tag, m_drain[i]), {31'd0, hd[i]},
          {31'd0, m_req[i] || (m_busy[i] > 0) || br_jump_vld || sys_jump_vld});
      chk($sformatf("%s.d%0d.redir_cnt", tag, m_drain[i]), rc[i], erc);
      chk($sformatf("%s.d%0d.drop_cnt", tag, m_drain[i]), dc[i], edc);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int nreq;
      nreq = int'(br_jump_vld) + int'(sys_jump_vld);
      if (m_req[i]) begin
        m_first[i] = 0;
        m_drop[i] += nreq;
        if (fetch_rdy) begin
          m_redir[i]++;
          m_req[i]  = 0;
          m_busy[i] = m_drain[i];
        end
      end else if (m_busy[i] > 0) begin
        m_busy[i]--;
        m_drop[i] += nreq;
      end else if (nreq > 0) begin
        m_req[i]   = 1;
        m_first[i] = 1;
        m_pc[i]    = (br_jump_vld ? br_jump_pc : sys_jump_pc) & ~`XLEN'(1);
        if (nreq == 2) m_drop[i]++;
      end
    end
  endtask

  task automatic step(input string tag, input logic b, input logic [`XLEN-1:0] bp,
                      input logic s, input logic [`XLEN-1:0] sp, input logic r);
    @(negedge clk);
    br_jump_vld = b; br_jump_pc = bp;
    sys_jump_vld = s; sys_jump_pc = sp;
    fetch_rdy = r;
    #1;
    check_all(tag);
    last_pc0 = rpc[0]; last_fl0 = fl[0]; last_vld0 = vld[0]; last_hd0 = hd[0];
    @(posedge clk);
    model_edge();
  endtask

  initial begin
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single sys request with odd PC, fetch always ready.
    step("sys1.req", 0, '0, 1, `XLEN'h1003, 1);
    step("sys1.n1", 0, '0, 0, '0, 1);
    chk("sys1.pc_const", last_pc0, 32'h0000_1002);
    chk("sys1.flush_const", {31'd0, last_fl0}, 32'd1);
    step("sys1.n2", 0, '0, 0, '0, 1);
    step("sys1.n3", 0, '0, 0, '0, 1);
    step("sys1.n4", 0, '0, 0, '0, 1);
    chk("sys1.hold_release", {31'd0, last_hd0}, 32'd0);

    // Simultaneous requests: branch wins.
    step("both.req", 1, `XLEN'h200, 1, `XLEN'h400, 1);
    step("both.n1", 0, '0, 0, '0, 1);
    chk("both.pc_const", last_pc0, 32'h0000_0200);
    for (int k = 0; k < 3; k++) step("both.tail", 0, '0, 0, '0, 1);

    // Backpressure: five not-ready cycles, accepted on the sixth.
    step("bp.req", 1, `XLEN'h3001, 0, '0, 0);
    for (int k = 0; k < 5; k++) begin
      step("bp.wait", 0, '0, 0, '0, 0);
      chk("bp.vld_const", {31'd0, last_vld0}, 32'd1);
      chk("bp.pc_const", last_pc0, 32'h0000_3000);
    end
    step("bp.acc", 0, '0, 0, '0, 1);
    for (int k = 0; k < 3; k++) step("bp.tail", 0, '0, 0, '0, 1);

    // Wrong-path requests during REQ and drain.
    step("wp.req", 0, '0, 1, `XLEN'h5000, 1);
    step("wp.r", 0, '0, 1, `XLEN'h6000, 1);
    step("wp.d1", 0, '0, 1, `XLEN'h7000, 0);
    step("wp.d2", 0, '0, 1, `XLEN'h8000, 0);
    for (int k = 0; k < 4; k++) step("wp.tail", 0, '0, 0, '0, 1);

    // Back-to-back: request right after acceptance.
    step("b2b.req1", 1, `XLEN'h9000, 0, '0, 1);
    step("b2b.acc1", 0, '0, 0, '0, 1);
    step("b2b.req2", 0, '0, 1, `XLEN'hA000, 1);
    for (int k = 0; k < 4; k++) step("b2b.tail", 0, '0, 0, '0, 1);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      logic b, s, r;
      b = ($urandom_range(0, 99) < 30);
      s = ($urandom_range(0, 99) < 30);
      r = ($urandom_range(0, 99) < 60);
      step("rnd", b, `XLEN'($urandom), s, `XLEN'($urandom), r);
    end
    for (int k = 0; k < 6; k++) step("drain_out", 0, '0, 0, '0, 1);

    // Asynchronous reset while the drain-2 instance is mid-DRAIN.
    step("ar.req", 1, `XLEN'hB003, 0, '0, 1);
    step("ar.acc", 0, '0, 0, '0, 1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step("ar.after", 0, '0, 1, `XLEN'hC000, 1);
    for (int k = 0; k < 4; k++) step("ar.tail", 0, '0, 0, '0, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
